irrigation_timer_ctrl: RTL and testbench
========================================

# irrigation_timer_ctrl

Sequencer for the irrigation timer: loads a BCD MM:SS duration, counts it down once per second, and drives the valve enable while time remains. It runs the four-digit down-counter chain itself: units digits count 9→0, tens digits count 5→0, and a borrow ripples from seconds-units up to minutes-tens. It sits between the user/preset logic and the valve driver and handles start, pause/resume, abort and completion.

## Interface
- TICKS_PER_SEC, default 1000: clock cycles per countdown second. Must be ≥2. The prescaler width is $clog2(TICKS_PER_SEC).
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low; sampled on the clock edge.
- start  in  1  level, sampled per cycle. In IDLE it loads the preset and starts. In PAUSED it resumes. Ignored elsewhere.
- pause  in  1  in RUN, moves to PAUSED. Ignored elsewhere.
- abort  in  1  from any non-IDLE state, returns to IDLE with the digits cleared.
- preset_min_t  in  3  minutes tens, 0–5.
- preset_min_u  in  4  minutes units, 0–9.
- preset_sec_t  in  3  seconds tens, 0–5.
- preset_sec_u  in  4  seconds units, 0–9.
- min_t, min_u, sec_t, sec_u  out  3/4/3/4  remaining time, registered.
- valve_on  out  1  high exactly while state is RUN.
- busy  out  1  high in LOAD, RUN and PAUSED.
- done  out  1  one-cycle pulse, high exactly while state is DONE.
- state  out  3  IDLE=0, LOAD=1, RUN=2, PAUSED=3, DONE=4.

## Operation
- Reset (reset=0 at an edge):
  - state goes to IDLE; all digits, the prescaler, valve_on, busy and done go to 0.
  - Reset overrides every other input.
- Input priority in the same cycle: abort > start > pause.
- Preset clamp at load: a tens value >5 loads as 5; a units value >9 loads as 9.
- IDLE:
  - start=1 loads the clamped preset into the digits, clears the prescaler, and moves to LOAD.
  - Digits hold their value in IDLE: 00:00 after reset, abort or completion.
- LOAD (one cycle): if all digits are 0, go to DONE; otherwise go to RUN. The valve never opens for a zero duration.
- RUN:
  - The prescaler increments each cycle.
  - At TICKS_PER_SEC−1 it wraps to 0 and produces a second tick that same edge.
- On a second tick, decrement MM:SS by one with borrow:
  - sec_u 0→9 borrows from sec_t.
  - sec_t 0→5 borrows from min_u.
  - min_u 0→9 borrows from min_t.
  - No wrap past 00:00 can occur: the tick that produces 00:00 also moves state to DONE.
- pause=1 in RUN: go to PAUSED.
  - Digits and prescaler are unchanged on that edge, including when a tick would have fired; pause wins and the tick is not lost.
- PAUSED: digits and prescaler hold; valve_on=0. start=1 returns to RUN, and counting resumes from the held prescaler value.
- DONE (one cycle): done=1, then unconditional move to IDLE. abort in DONE also goes to IDLE; no difference is visible.
- abort in LOAD, RUN or PAUSED: go to IDLE, clear digits and prescaler to 0. No done pulse is generated.
- start held high across DONE→IDLE re-arms immediately, reloading the preset. This is required behaviour.

## Timing
- All outputs are registered and change only on the clock edge.
- Start sampled in IDLE at edge k:
  - digits are loaded at k; LOAD is visible after k;
  - RUN (valve_on=1) is visible after k+1.
- First decrement: TICKS_PER_SEC edges after entering RUN.
- Preset of N seconds (N>0) with no pause: valve_on is high for exactly N·TICKS_PER_SEC cycles.
  - done is high on the cycle immediately after valve_on falls.
  - state returns to IDLE one cycle later.
- Pause latency is one edge. Resume latency is one edge. Paused cycles add exactly their count to the total run time.
- Abort latency is one edge. valve_on is low in the cycle after abort is sampled.

## Test plan
- TICKS_PER_SEC=4, preset 00:03, pulse start. Required:
  - LOAD for 1 cycle;
  - valve_on high for 12 cycles, with digits 00:03→00:02→00:01→00:00 every 4 cycles;
  - done=1 for 1 cycle, then state=0.
- Borrow chain: preset 10:00, run 1 tick. Required: 09:59. Then preset 01:00 → 00:59.
- Preset 00:00 with start. Required: state sequence IDLE→LOAD→DONE→IDLE, valve_on never 1, done pulses once.
- Pause exactly on the wrap cycle (prescaler=3), hold 5 cycles, then start. Required:
  - digits unchanged during the pause;
  - decrement on the first RUN edge after resume;
  - total valve-on time equals the unpaused time.
- Abort mid-RUN at 00:02, and separately abort and start together. Required: next state IDLE, digits 00:00, no done pulse, valve_on 0.
- Clamp and reset: preset tens=7 / units=12 loads as 59:59. Assert reset=0 mid-RUN. Required: all outputs 0 and state IDLE after that edge; start during reset is ignored.

Source files
------------

// File: rtl/irrigation_timer_ctrl_if.sv
// irrigation_timer_ctrl_if: control, preset and status bundle between the user/preset logic and the timer.
// master: drives start/pause/abort and the BCD preset, and observes the remaining time and status.
// slave: the timer side.
interface irrigation_timer_ctrl_if;
  logic       start;
  logic       pause;
  logic       abort;
  logic [2:0] preset_min_t;
  logic [3:0] preset_min_u;
  logic [2:0] preset_sec_t;
  logic [3:0] preset_sec_u;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic       valve_on;
  logic       busy;
  logic       done;
  logic [2:0] state;
  modport master (
    output start, pause, abort, preset_min_t, preset_min_u, preset_sec_t, preset_sec_u,
    input  min_t, min_u, sec_t, sec_u, valve_on, busy, done, state
  );
  modport slave (
    input  start, pause, abort, preset_min_t, preset_min_u, preset_sec_t, preset_sec_u,
    output min_t, min_u, sec_t, sec_u, valve_on, busy, done, state
  );
endinterface

// File: rtl/irrigation_timer_ctrl.sv
// irrigation_timer_ctrl: loads a BCD MM:SS duration, counts it down once per second and opens the valve while time remains.
// clock: sole clock. reset: synchronous, active-low.
// bus (slave): start/pause/abort and the preset in; remaining digits, valve_on, busy, done and state out.
module irrigation_timer_ctrl #(
  parameter int TICKS_PER_SEC = 1000
) (
  input logic clock,
  input logic reset,
  irrigation_timer_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, PAUSED = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_n;
  logic [2:0] mt_q, mt_n, st_q, st_n, dmt, dst;
  logic [3:0] mu_q, mu_n, su_q, su_n, dmu, dsu;
  logic [PW-1:0] presc_q, presc_n;
  logic valve_q, busy_q, done_q;
  logic tick, last_sec, advance;
  always_comb begin
    tick = presc_q == LAST;
    last_sec = {mt_q, mu_q, st_q, su_q} == 14'd1;
    // Borrow ripples upward only through digits that are already zero.
    dsu = su_q == 4'd0 ? 4'd9 : su_q - 4'd1;
    dst = su_q != 4'd0 ? st_q : (st_q == 3'd0 ? 3'd5 : st_q - 3'd1);
    dmu = (su_q != 4'd0 || st_q != 3'd0) ? mu_q : (mu_q == 4'd0 ? 4'd9 : mu_q - 4'd1);
    dmt = (su_q != 4'd0 || st_q != 3'd0 || mu_q != 4'd0) ? mt_q : mt_q - 3'd1;
    // The resume edge counts like a RUN edge, so a tick held off by pause fires
    // there and the paused interval adds exactly its own length to the run.
    advance = (state_q == RUN && !bus.pause) || (state_q == PAUSED && bus.start);
    state_n = state_q;
    mt_n = mt_q;
    mu_n = mu_q;
    st_n = st_q;
    su_n = su_q;
    presc_n = presc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_n = LOAD;
          mt_n = bus.preset_min_t > 3'd5 ? 3'd5 : bus.preset_min_t;
          mu_n = bus.preset_min_u > 4'd9 ? 4'd9 : bus.preset_min_u;
          st_n = bus.preset_sec_t > 3'd5 ? 3'd5 : bus.preset_sec_t;
          su_n = bus.preset_sec_u > 4'd9 ? 4'd9 : bus.preset_sec_u;
          presc_n = '0;
        end
      end
      LOAD: state_n = {mt_q, mu_q, st_q, su_q} == 14'd0 ? DONE : RUN;
      RUN: state_n = PAUSED;
      PAUSED: state_n = PAUSED;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (advance) begin
      presc_n = tick ? '0 : presc_q + 1'b1;
      state_n = tick && last_sec ? DONE : RUN;
      if (tick) begin
        mt_n = dmt;
        mu_n = dmu;
        st_n = dst;
        su_n = dsu;
      end
    end
    if (bus.abort && state_q != IDLE) begin
      state_n = IDLE;
      mt_n = '0;
      mu_n = '0;
      st_n = '0;
      su_n = '0;
      presc_n = '0;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      mt_q <= '0;
      mu_q <= '0;
      st_q <= '0;
      su_q <= '0;
      presc_q <= '0;
      valve_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_n;
      mt_q <= mt_n;
      mu_q <= mu_n;
      st_q <= st_n;
      su_q <= su_n;
      presc_q <= presc_n;
      valve_q <= state_n == RUN;
      busy_q <= state_n == LOAD || state_n == RUN || state_n == PAUSED;
      done_q <= state_n == DONE;
    end
  end
  assign bus.min_t = mt_q;
  assign bus.min_u = mu_q;
  assign bus.sec_t = st_q;
  assign bus.sec_u = su_q;
  assign bus.valve_on = valve_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// tb_irrigation_timer_ctrl: directed scenarios for the irrigation timer with TICKS_PER_SEC=4.
module tb_irrigation_timer_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  irrigation_timer_ctrl_if bus ();
  irrigation_timer_ctrl #(.TICKS_PER_SEC(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  logic [13:0] tm;
  assign tm = {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
  function automatic logic [13:0] bcd(input int a, input int b, input int c, input int d);
    return {3'(a), 4'(b), 3'(c), 4'(d)};
  endfunction
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic set_preset(input int a, input int b, input int c, input int d);
    bus.preset_min_t = 3'(a);
    bus.preset_min_u = 4'(b);
    bus.preset_sec_t = 3'(c);
    bus.preset_sec_u = 4'(d);
  endtask
  task automatic test_reset;
    reset = 1'b0;
    bus.start = 1'b1;
    repeat (2) step;
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    checks++;
    if (tm !== 14'd0 || bus.valve_on !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: time=%h valve=%b busy=%b done=%b want all 0", tm, bus.valve_on, bus.busy, bus.done);
    end
    bus.start = 1'b0;
    reset = 1'b1;
    step;
  endtask
  task automatic test_basic;
    int cnt;
    set_preset(0, 0, 0, 3);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 3'd1 || bus.busy !== 1'b1 || bus.valve_on !== 1'b0 || tm !== bcd(0, 0, 0, 3)) begin
      errors++; $display("FAIL basic_load: state=%0d busy=%b valve=%b time=%h want 1/1/0/%h", bus.state, bus.busy, bus.valve_on, tm, bcd(0, 0, 0, 3));
    end
    step;
    cnt = 0;
    while (bus.valve_on && cnt < 40) begin
      checks++;
      if (tm !== bcd(0, 0, 0, 3 - cnt / 4) || bus.state !== 3'd2) begin
        errors++; $display("FAIL basic_count[%0d]: time=%h state=%0d want %h/2", cnt, tm, bus.state, bcd(0, 0, 0, 3 - cnt / 4));
      end
      cnt++;
      step;
    end
    checks++;
    if (cnt !== 12) begin errors++; $display("FAIL basic_valve_cycles: got %0d want 12", cnt); end
    checks++;
    if (bus.state !== 3'd4 || bus.done !== 1'b1 || tm !== 14'd0) begin
      errors++; $display("FAIL basic_done: state=%0d done=%b time=%h want 4/1/0", bus.state, bus.done, tm);
    end
    step;
    checks++;
    if (bus.state !== 3'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: state=%0d done=%b busy=%b want 0/0/0", bus.state, bus.done, bus.busy);
    end
  endtask
  task automatic test_borrow;
    set_preset(1, 0, 0, 0);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    repeat (5) step;
    checks++;
    if (tm !== bcd(0, 9, 5, 9) || bus.valve_on !== 1'b1) begin
      errors++; $display("FAIL borrow_10_00: time=%h valve=%b want %h/1", tm, bus.valve_on, bcd(0, 9, 5, 9));
    end
    bus.abort = 1'b1;
    step;
    bus.abort = 1'b0;
    set_preset(0, 1, 0, 0);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    repeat (5) step;
    checks++;
    if (tm !== bcd(0, 0, 5, 9) || bus.valve_on !== 1'b1) begin
      errors++; $display("FAIL borrow_01_00: time=%h valve=%b want %h/1", tm, bus.valve_on, bcd(0, 0, 5, 9));
    end
    bus.abort = 1'b1;
    step;
    bus.abort = 1'b0;
  endtask
  task automatic test_zero;
    set_preset(0, 0, 0, 0);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 3'd1 || bus.valve_on !== 1'b0) begin errors++; $display("FAIL zero_load: state=%0d valve=%b want 1/0", bus.state, bus.valve_on); end
    step;
    checks++;
    if (bus.state !== 3'd4 || bus.done !== 1'b1 || bus.valve_on !== 1'b0) begin
      errors++; $display("FAIL zero_done: state=%0d done=%b valve=%b want 4/1/0", bus.state, bus.done, bus.valve_on);
    end
    step;
    checks++;
    if (bus.state !== 3'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL zero_idle: state=%0d done=%b want 0/0", bus.state, bus.done); end
    step;
    checks++;
    if (bus.done !== 1'b0 || bus.valve_on !== 1'b0) begin errors++; $display("FAIL zero_single_pulse: done=%b valve=%b want 0/0", bus.done, bus.valve_on); end
  endtask
  task automatic test_pause;
    int cnt;
    set_preset(0, 0, 0, 2);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    step;
    cnt = bus.valve_on ? 1 : 0;
    repeat (3) begin
      step;
      if (bus.valve_on) cnt++;
    end
    bus.pause = 1'b1;
    step;
    bus.pause = 1'b0;
    checks++;
    if (bus.state !== 3'd3 || tm !== bcd(0, 0, 0, 2) || bus.valve_on !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL pause_enter: state=%0d time=%h valve=%b busy=%b want 3/%h/0/1", bus.state, tm, bus.valve_on, bus.busy, bcd(0, 0, 0, 2));
    end
    repeat (4) begin
      step;
      checks++;
      if (bus.state !== 3'd3 || tm !== bcd(0, 0, 0, 2)) begin
        errors++; $display("FAIL pause_hold: state=%0d time=%h want 3/%h", bus.state, tm, bcd(0, 0, 0, 2));
      end
    end
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 3'd2 || tm !== bcd(0, 0, 0, 1)) begin
      errors++; $display("FAIL pause_resume_tick: state=%0d time=%h want 2/%h", bus.state, tm, bcd(0, 0, 0, 1));
    end
    if (bus.valve_on) cnt++;
    for (int i = 0; i < 20 && bus.valve_on; i++) begin
      step;
      if (bus.valve_on) cnt++;
    end
    checks++;
    if (cnt !== 8 || bus.done !== 1'b1) begin errors++; $display("FAIL pause_total_valve: cycles=%0d done=%b want 8/1", cnt, bus.done); end
    step;
  endtask
  task automatic test_abort;
    set_preset(0, 0, 0, 3);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    repeat (5) step;
    checks++;
    if (tm !== bcd(0, 0, 0, 2)) begin errors++; $display("FAIL abort_setup: time=%h want %h", tm, bcd(0, 0, 0, 2)); end
    bus.abort = 1'b1;
    step;
    bus.abort = 1'b0;
    checks++;
    if (bus.state !== 3'd0 || tm !== 14'd0 || bus.valve_on !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_run: state=%0d time=%h valve=%b done=%b busy=%b want 0/0/0/0/0", bus.state, tm, bus.valve_on, bus.done, bus.busy);
    end
    step;
    checks++;
    if (bus.done !== 1'b0 || bus.state !== 3'd0) begin errors++; $display("FAIL abort_no_done: done=%b state=%0d want 0/0", bus.done, bus.state); end
    bus.start = 1'b1;
    step;
    step;
    bus.abort = 1'b1;
    step;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 3'd0 || tm !== 14'd0 || bus.valve_on !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_with_start: state=%0d time=%h valve=%b done=%b want 0/0/0/0", bus.state, tm, bus.valve_on, bus.done);
    end
  endtask
  task automatic test_clamp_reset;
    set_preset(7, 12, 7, 12);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    checks++;
    if (tm !== bcd(5, 9, 5, 9)) begin errors++; $display("FAIL clamp_load: time=%h want %h", tm, bcd(5, 9, 5, 9)); end
    repeat (3) step;
    checks++;
    if (bus.state !== 3'd2) begin errors++; $display("FAIL clamp_run: state=%0d want 2", bus.state); end
    reset = 1'b0;
    bus.start = 1'b1;
    step;
    checks++;
    if (bus.state !== 3'd0 || tm !== 14'd0 || bus.valve_on !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run: state=%0d time=%h valve=%b busy=%b done=%b want all 0", bus.state, tm, bus.valve_on, bus.busy, bus.done);
    end
    step;
    checks++;
    if (bus.state !== 3'd0 || tm !== 14'd0) begin errors++; $display("FAIL reset_start_ignored: state=%0d time=%h want 0/0", bus.state, tm); end
    bus.start = 1'b0;
    reset = 1'b1;
    step;
  endtask
  task automatic test_back_to_back;
    set_preset(0, 0, 0, 1);
    bus.start = 1'b1;
    step;
    step;
    repeat (4) step;
    checks++;
    if (bus.state !== 3'd4 || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done: state=%0d done=%b want 4/1", bus.state, bus.done); end
    step;
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL b2b_idle: state=%0d want 0", bus.state); end
    step;
    checks++;
    if (bus.state !== 3'd1 || tm !== bcd(0, 0, 0, 1)) begin errors++; $display("FAIL b2b_rearm: state=%0d time=%h want 1/%h", bus.state, tm, bcd(0, 0, 0, 1)); end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    step;
    bus.abort = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    set_preset(0, 0, 0, 0);
    test_reset;
    test_basic;
    test_borrow;
    test_zero;
    test_pause;
    test_abort;
    test_clamp_reset;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
